// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, opcode values and instruction field positions for the sequencer
package seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} seq_state_t;
  localparam logic [1:0] OP_MV   = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MULT = 2'b11;
  localparam int II_POS = 14;
  localparam int M_POS  = 13;
  localparam int X_POS  = 12;
  localparam int Y_POS  = 11;
  localparam int IW     = 16;
endpackage

// File: rtl/seq_prog_mem.sv
// seq_prog_mem: DEPTH x 16 program store, one write port, combinational read
module seq_prog_mem import seq_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);
  logic [IW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues a stored program to the processor over its run/done handshake.
// Define SEQ_WDOG_EN to add the done-timeout watchdog and its wdog_err output.
module instr_sequencer import seq_pkg::*; #(
  parameter int DEPTH = 16
`ifdef SEQ_WDOG_EN
  , parameter int WDOG_CYCLES = 16
`endif
  , localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   prog_len,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          proc_done,
  output logic          proc_run,
  output logic [15:0]   proc_instr,
  output logic          busy,
  output logic          finished,
  output logic [AW-1:0] pc,
  output logic [15:0]   icount
`ifdef SEQ_WDOG_EN
  , output logic        wdog_err
`endif
);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  seq_state_t state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0] icount_q, icount_d, instr_q, instr_d, rdata;
  logic finished_q, finished_d, abort_q, abort_d, we;
`ifdef SEQ_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES) + 1;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic wdog_q, wdog_d;
`endif
  assign we = prog_we && state_q == IDLE;
  seq_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk), .we_i(we), .waddr_i(prog_addr), .wdata_i(prog_data),
    .raddr_i(pc_d), .rdata_o(rdata)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    pc_d = pc_q;
    icount_d = icount_q;
    finished_d = finished_q;
    instr_d = instr_q;
`ifdef SEQ_WDOG_EN
    wdog_d = wdog_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        len_d = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
        pc_d = '0;
        icount_d = '0;
        finished_d = len_d == '0;
        state_d = (len_d == '0) ? IDLE : ISSUE;
`ifdef SEQ_WDOG_EN
        wdog_d = 1'b0;
`endif
      end
      ISSUE: state_d = WAIT;
      WAIT: if (proc_done) begin
        icount_d = icount_q + {15'd0, ~&icount_q};
        if (abort_q || abort) state_d = IDLE;
        else if ({1'b0, pc_q} == len_q - 1'b1) begin
          state_d = IDLE;
          finished_d = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
          state_d = ISSUE;
        end
      end
`ifdef SEQ_WDOG_EN
      else if (wcnt_q == WW'(WDOG_CYCLES - 1)) begin
        wdog_d = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // A write landing in the same cycle as the fetch must be forwarded
    if (state_d == ISSUE) instr_d = (we && prog_addr == pc_d) ? prog_data : rdata;
    abort_d = state_d != IDLE && (abort_q || (abort && state_q != IDLE));
`ifdef SEQ_WDOG_EN
    wcnt_d = (state_q == WAIT && state_d == WAIT) ? wcnt_q + 1'b1 : '0;
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q <= '0;
      pc_q <= '0;
      icount_q <= '0;
      finished_q <= 1'b0;
      abort_q <= 1'b0;
      instr_q <= '0;
`ifdef SEQ_WDOG_EN
      wcnt_q <= '0;
      wdog_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      pc_q <= pc_d;
      icount_q <= icount_d;
      finished_q <= finished_d;
      abort_q <= abort_d;
      instr_q <= instr_d;
`ifdef SEQ_WDOG_EN
      wcnt_q <= wcnt_d;
      wdog_q <= wdog_d;
`endif
    end
  end
  assign proc_run = state_q == ISSUE;
  assign busy = state_q != IDLE;
  assign proc_instr = instr_q;
  assign finished = finished_q;
  assign pc = pc_q;
  assign icount = icount_q;
`ifdef SEQ_WDOG_EN
  assign wdog_err = wdog_q;
`endif
endmodule
